// File: rtl/lane_deskew.sv
// Four-lane deskew buffer: each lane locks on a COM symbol, buffers into a small FIFO,
// and all lanes are popped together once every head is present and agrees on COM-ness.
module lane_deskew #(
  parameter int            BITS  = 7,
  parameter int            DEPTH = 4,
  parameter logic [BITS:0] COM   = 8'hBC
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [BITS:0] LANE0,
  input  logic [BITS:0] LANE1,
  input  logic [BITS:0] LANE2,
  input  logic [BITS:0] LANE3,
  input  logic          DK_0,
  input  logic          DK_1,
  input  logic          DK_2,
  input  logic          DK_3,
  output logic [BITS:0] OUT_LANE0,
  output logic [BITS:0] OUT_LANE1,
  output logic [BITS:0] OUT_LANE2,
  output logic [BITS:0] OUT_LANE3,
  output logic          OUT_DK_0,
  output logic          OUT_DK_1,
  output logic          OUT_DK_2,
  output logic          OUT_DK_3,
  output logic          ALIGNED,
  output logic          DESKEW_ERR
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_SEARCH, ST_ALIGNED, ST_ERROR} state_t;

  logic [BITS:0] sym [4];
  logic [3:0]    dk;

  assign sym[0] = LANE0;
  assign sym[1] = LANE1;
  assign sym[2] = LANE2;
  assign sym[3] = LANE3;
  assign dk     = {DK_3, DK_2, DK_1, DK_0};

  state_t        state_q, state_d;
  logic [BITS:0] mem_q [4][DEPTH];
  logic [BITS:0] mem_d [4][DEPTH];
  logic [AW-1:0] wr_ptr_q [4], wr_ptr_d [4];
  logic [AW-1:0] rd_ptr_q [4], rd_ptr_d [4];
  logic [AW:0]   cnt_q [4], cnt_d [4];
  logic [3:0]    lock_q, lock_d;
  logic [BITS:0] out_lane_q [4], out_lane_d [4];
  logic          out_dk_q, out_dk_d;
  logic          aligned_q, aligned_d;
  logic          err_q, err_d;

  logic [3:0] empty, full, head_com, wr, wren;
  logic       agree, pop, mismatch, ovf, flush;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i]    = (cnt_q[i] == '0);
      full[i]     = (cnt_q[i] == CNT_FULL);
      head_com[i] = (mem_q[i][rd_ptr_q[i]] == COM);
      // Unlocked lanes accept only a valid COM; everything is ignored while in ERROR.
      wr[i]       = (state_q != ST_ERROR) && dk[i] && (lock_q[i] || (sym[i] == COM));
    end
    agree    = (&head_com) || (~|head_com);
    pop      = (state_q == ST_ALIGNED) && (~|empty) && agree;
    mismatch = (state_q == ST_ALIGNED) && (~|empty) && !agree;
    ovf      = (|(wr & full)) && !pop;
    flush    = ovf || mismatch || (state_q == ST_ERROR);
    wren     = flush ? 4'b0000 : wr;
    lock_d   = flush ? 4'b0000 : (lock_q | wr);

    mem_d = mem_q;
    for (int i = 0; i < 4; i++) begin
      if (wren[i]) mem_d[i][wr_ptr_q[i]] = sym[i];
      wr_ptr_d[i]   = flush ? '0 : wr_ptr_q[i] + AW'(wren[i]);
      rd_ptr_d[i]   = flush ? '0 : rd_ptr_q[i] + AW'(pop);
      cnt_d[i]      = flush ? '0 : cnt_q[i] + (AW+1)'(wren[i]) - (AW+1)'(pop);
      out_lane_d[i] = pop ? mem_q[i][rd_ptr_q[i]] : out_lane_q[i];
    end

    state_d = state_q;
    case (state_q)
      ST_SEARCH:  if (ovf) state_d = ST_ERROR;
                  else if (&lock_d) state_d = ST_ALIGNED;
      ST_ALIGNED: if (ovf || mismatch) state_d = ST_ERROR;
      default:    state_d = ST_SEARCH;
    endcase

    out_dk_d  = pop;
    aligned_d = (state_d == ST_ALIGNED);
    err_d     = (state_d == ST_ERROR);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_SEARCH;
      lock_q    <= '0;
      out_dk_q  <= 1'b0;
      aligned_q <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i]   <= '0;
        rd_ptr_q[i]   <= '0;
        cnt_q[i]      <= '0;
        out_lane_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      out_dk_q  <= out_dk_d;
      aligned_q <= aligned_d;
      err_q     <= err_d;
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i]   <= wr_ptr_d[i];
        rd_ptr_q[i]   <= rd_ptr_d[i];
        cnt_q[i]      <= cnt_d[i];
        out_lane_q[i] <= out_lane_d[i];
      end
    end
  end

  // Symbol storage carries no reset; occupancy counters alone define validity.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign OUT_LANE0  = out_lane_q[0];
  assign OUT_LANE1  = out_lane_q[1];
  assign OUT_LANE2  = out_lane_q[2];
  assign OUT_LANE3  = out_lane_q[3];
  assign OUT_DK_0   = out_dk_q;
  assign OUT_DK_1   = out_dk_q;
  assign OUT_DK_2   = out_dk_q;
  assign OUT_DK_3   = out_dk_q;
  assign ALIGNED    = aligned_q;
  assign DESKEW_ERR = err_q;

endmodule

// File: tb/tb_lane_deskew.sv
// Directed bench for lane_deskew: zero skew, tolerated and excessive skew,
// COM mismatch, per-lane valid gaps and mid-stream reset.
module tb_lane_deskew;
  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] lane_v [4];
  logic       dk_v [4];
  logic [7:0] out_v [4];
  logic       out_dk [4];
  logic       aligned, err;
  int         checks = 0;
  int         failures = 0;

  logic [7:0] seq [6];
  logic [7:0] gv012 [10], gv3 [10], gexp_v [10];
  logic       gd012 [10], gd3 [10], gexp_d [10];

  always #5 CLK = ~CLK;

  lane_deskew #(.BITS(7), .DEPTH(4), .COM(8'hBC)) dut (
    .CLK(CLK), .RESET(RESET),
    .LANE0(lane_v[0]), .LANE1(lane_v[1]), .LANE2(lane_v[2]), .LANE3(lane_v[3]),
    .DK_0(dk_v[0]), .DK_1(dk_v[1]), .DK_2(dk_v[2]), .DK_3(dk_v[3]),
    .OUT_LANE0(out_v[0]), .OUT_LANE1(out_v[1]), .OUT_LANE2(out_v[2]), .OUT_LANE3(out_v[3]),
    .OUT_DK_0(out_dk[0]), .OUT_DK_1(out_dk[1]), .OUT_DK_2(out_dk[2]), .OUT_DK_3(out_dk[3]),
    .ALIGNED(aligned), .DESKEW_ERR(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] v, input logic d);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_lane%0d", tag, i), 32'(out_v[i]), 32'(v));
      chk($sformatf("%s_dk%0d", tag, i), 32'(out_dk[i]), 32'(d));
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_all(input logic [7:0] v, input logic d);
    for (int i = 0; i < 4; i++) begin
      lane_v[i] = v;
      dk_v[i]   = d;
    end
  endtask

  task automatic set_lane(input int i, input logic [7:0] v, input logic d);
    lane_v[i] = v;
    dk_v[i]   = d;
  endtask

  task automatic pulse_reset();
    set_all(8'h00, 1'b0);
    RESET = 1'b1;
    #3;
    RESET = 1'b0;
  endtask

  initial begin
    seq = '{8'hBC, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    gv012  = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    gd012  = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    gv3    = '{8'hBC, 8'h01, 8'h00, 8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00};
    gd3    = '{1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
    gexp_v = '{8'h00, 8'hBC, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h05};
    gexp_d = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0};

    // Reset state
    RESET = 1'b1;
    set_all(8'h00, 1'b0);
    #2;
    chk_out("rst", 8'h00, 1'b0);
    chk("rst_aligned", 32'(aligned), 0);
    chk("rst_err", 32'(err), 0);
    #2 RESET = 1'b0;

    // Zero skew
    set_all(8'hBC, 1'b1); tick();
    chk("zs_aligned", 32'(aligned), 1);
    chk("zs_first_dk", 32'(out_dk[0]), 0);
    set_all(8'h11, 1'b1); tick(); chk_out("zs_bc", 8'hBC, 1'b1);
    set_all(8'h22, 1'b1); tick(); chk_out("zs_11", 8'h11, 1'b1);
    set_all(8'h00, 1'b0); tick(); chk_out("zs_22", 8'h22, 1'b1);
    chk("zs_err", 32'(err), 0);
    tick(); chk_out("zs_idle", 8'h22, 1'b0);
    chk("zs_aligned_hold", 32'(aligned), 1);

    // Lane 2 three cycles late: tolerated
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 2) begin
          if (c >= 3 && c < 9) set_lane(i, seq[c-3], 1'b1); else set_lane(i, 8'h00, 1'b0);
        end else begin
          if (c < 6) set_lane(i, seq[c], 1'b1); else set_lane(i, 8'h00, 1'b0);
        end
      end
      tick();
      if (c >= 4) chk_out($sformatf("sk3_c%0d", c), seq[c-4], 1'b1);
      else        chk_out($sformatf("sk3_c%0d", c), 8'h00, 1'b0);
      chk($sformatf("sk3_aligned_c%0d", c), 32'(aligned), (c >= 3) ? 1 : 0);
      chk($sformatf("sk3_err_c%0d", c), 32'(err), 0);
    end

    // Lane 2 four cycles late: overflow
    pulse_reset();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 2) set_lane(i, 8'hBC, (c == 4));
        else        set_lane(i, seq[c], 1'b1);
      end
      tick();
      chk($sformatf("sk4_err_c%0d", c), 32'(err), (c == 4) ? 1 : 0);
      chk($sformatf("sk4_aligned_c%0d", c), 32'(aligned), 0);
    end
    chk_out("sk4_errdk", 8'h00, 1'b0);
    set_all(8'hBC, 1'b1); tick();
    chk("sk4_err_clear", 32'(err), 0);
    chk("sk4_ignored", 32'(aligned), 0);
    set_all(8'hBC, 1'b1); tick();
    chk("sk4_relock", 32'(aligned), 1);
    set_all(8'h11, 1'b1); tick(); chk_out("sk4_bc", 8'hBC, 1'b1);
    set_all(8'h00, 1'b0); tick(); chk_out("sk4_11", 8'h11, 1'b1);

    // COM mismatch while aligned
    pulse_reset();
    set_all(8'hBC, 1'b1); tick();
    set_all(8'h11, 1'b1); tick(); chk_out("mm_bc", 8'hBC, 1'b1);
    set_all(8'hBC, 1'b1); set_lane(1, 8'h55, 1'b1); tick(); chk_out("mm_11", 8'h11, 1'b1);
    set_all(8'h22, 1'b1); tick();
    chk("mm_err", 32'(err), 1);
    chk("mm_aligned", 32'(aligned), 0);
    chk_out("mm_nopop", 8'h11, 1'b0);
    set_all(8'h33, 1'b1); tick();
    chk("mm_err_end", 32'(err), 0);
    chk_out("mm_errcyc", 8'h11, 1'b0);
    set_all(8'hBC, 1'b1); tick();
    chk("mm_relock", 32'(aligned), 1);
    set_all(8'h66, 1'b1); tick(); chk_out("mm_bc2", 8'hBC, 1'b1);
    set_all(8'h00, 1'b0); tick(); chk_out("mm_66", 8'h66, 1'b1);

    // Lane 3 valid gap of two cycles
    pulse_reset();
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 3; i++) set_lane(i, gv012[c], gd012[c]);
      set_lane(3, gv3[c], gd3[c]);
      tick();
      chk_out($sformatf("gap_c%0d", c), gexp_v[c], gexp_d[c]);
      chk($sformatf("gap_err_c%0d", c), 32'(err), 0);
    end

    // Reset with three buffered entries
    pulse_reset();
    set_all(8'hBC, 1'b1); tick();
    set_all(8'h11, 1'b1); set_lane(3, 8'h00, 1'b0); tick(); chk_out("rs_bc", 8'hBC, 1'b1);
    set_all(8'h22, 1'b1); set_lane(3, 8'h00, 1'b0); tick();
    set_all(8'h33, 1'b1); set_lane(3, 8'h00, 1'b0); tick();
    chk("rs_pre_aligned", 32'(aligned), 1);
    chk("rs_pre_lane0", 32'(out_v[0]), 32'hBC);
    RESET = 1'b1;
    #1;
    chk_out("rs_async", 8'h00, 1'b0);
    chk("rs_async_aligned", 32'(aligned), 0);
    chk("rs_async_err", 32'(err), 0);
    #2 RESET = 1'b0;
    set_all(8'h44, 1'b1); tick();
    chk("rs_post_aligned1", 32'(aligned), 0);
    set_all(8'h55, 1'b1); tick();
    set_all(8'h00, 1'b0); tick();
    chk_out("rs_post", 8'h00, 1'b0);
    chk("rs_post_aligned2", 32'(aligned), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
